// File: rtl/coax_tx_framer.sv
// Transmit framer for the SPI-over-coax link: wraps each accepted word as sync + data + even
// parity and drives it as a Manchester stream with a registered line-driver enable.
module coax_tx_framer #(
  parameter int          DATA_WIDTH      = 32,
  parameter int          HALF_BIT_CYCLES = 1,
  parameter logic [7:0]  SYNC_PATTERN    = 8'hA5,
  parameter int          GAP_BITS        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  tx_out,
  output logic                  tx_oe,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  localparam int MAX_FIELD = (DATA_WIDTH > GAP_BITS) ? DATA_WIDTH : GAP_BITS;
  localparam int BIT_W     = $clog2(MAX_FIELD);
  localparam int HC_W      = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam int IDX_W     = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_t;

  state_t                  state_q, state_d, next_field;
  logic [HC_W-1:0]         half_cnt_q, half_cnt_d;
  logic                    phase_q, phase_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    parity_q, parity_d;
  logic                    tx_out_q, tx_out_d;
  logic                    tx_oe_q, tx_oe_d;
  logic                    frame_done_q, frame_done_d;
  logic [15:0]             frame_count_q, frame_count_d;
  logic                    half_last, field_last, line_bit;
  logic [2:0]              sync_idx;
  logic [IDX_W-1:0]        data_idx;

  // Handshake: a word transfers on a rising edge where din_valid && din_ready; din_ready
  // depends on state only, and din_valid without din_ready is simply ignored.
  assign din_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx_out      = tx_out_q;
  assign tx_oe       = tx_oe_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

  always_comb begin
    field_last = 1'b0;
    next_field = IDLE;
    case (state_q)
      SYNC:    begin field_last = (bit_cnt_q == BIT_W'(7));            next_field = DATA;   end
      DATA:    begin field_last = (bit_cnt_q == BIT_W'(DATA_WIDTH-1)); next_field = PARITY; end
      PARITY:  begin field_last = 1'b1;                                 next_field = GAP;    end
      GAP:     begin field_last = (bit_cnt_q == BIT_W'(GAP_BITS-1));   next_field = IDLE;   end
      default: begin field_last = 1'b0;                                 next_field = IDLE;   end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    parity_d   = parity_q;
    half_last  = (half_cnt_q == HC_W'(HALF_BIT_CYCLES-1));
    if (state_q == IDLE) begin
      half_cnt_d = '0;
      phase_d    = 1'b0;
      bit_cnt_d  = '0;
      if (din_valid) begin
        data_d   = din;
        parity_d = ^din;
        state_d  = SYNC;
      end
    end else if (half_last) begin
      half_cnt_d = '0;
      phase_d    = ~phase_q;
      // Field changes only at the end of a bit's second half.
      if (phase_q) begin
        if (field_last) begin
          bit_cnt_d = '0;
          state_d   = next_field;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
    end else begin
      half_cnt_d = half_cnt_q + HC_W'(1);
    end
  end

  // The line flops are loaded with the half-bit for the position being entered, so the
  // first sync half appears on the same edge that accepts the word.
  always_comb begin
    sync_idx = 3'd7 - bit_cnt_d[2:0];
    data_idx = IDX_W'(DATA_WIDTH-1) - IDX_W'(bit_cnt_d);
    line_bit = 1'b0;
    tx_oe_d  = 1'b0;
    case (state_d)
      SYNC:    begin line_bit = SYNC_PATTERN[sync_idx]; tx_oe_d = 1'b1; end
      DATA:    begin line_bit = data_d[data_idx];       tx_oe_d = 1'b1; end
      PARITY:  begin line_bit = parity_d;               tx_oe_d = 1'b1; end
      default: begin line_bit = 1'b0;                   tx_oe_d = 1'b0; end
    endcase
    tx_out_d      = tx_oe_d & (line_bit ^ phase_d);
    frame_done_d  = (state_q == PARITY) && (state_d == GAP);
    frame_count_d = frame_count_q;
    if (frame_done_d) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      half_cnt_q    <= '0;
      phase_q       <= 1'b0;
      bit_cnt_q     <= '0;
      data_q        <= '0;
      parity_q      <= 1'b0;
      tx_out_q      <= 1'b0;
      tx_oe_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      half_cnt_q    <= half_cnt_d;
      phase_q       <= phase_d;
      bit_cnt_q     <= bit_cnt_d;
      data_q        <= data_d;
      parity_q      <= parity_d;
      tx_out_q      <= tx_out_d;
      tx_oe_q       <= tx_oe_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_coax_tx_framer.sv
// Directed bench for coax_tx_framer: default instance plus a HALF_BIT_CYCLES=3 instance.
module tb_coax_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0, din3 = '0;
  logic        din_valid = 1'b0, din_valid3 = 1'b0;
  logic        din_ready, tx_out, tx_oe, busy, frame_done;
  logic        din_ready3, tx_out3, tx_oe3, busy3, frame_done3;
  logic [15:0] frame_count, frame_count3;

  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  coax_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .tx_out(tx_out), .tx_oe(tx_oe), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  coax_tx_framer #(.HALF_BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .din_valid(din_valid3), .din_ready(din_ready3),
    .tx_out(tx_out3), .tx_oe(tx_oe3), .busy(busy3), .frame_done(frame_done3),
    .frame_count(frame_count3)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_oe(input bit sel);
    return sel ? tx_oe3 : tx_oe;
  endfunction
  function automatic logic cur_out(input bit sel);
    return sel ? tx_out3 : tx_out;
  endfunction
  function automatic logic cur_fd(input bit sel);
    return sel ? frame_done3 : frame_done;
  endfunction

  // Reference Manchester model: bit 1 -> high,low; bit 0 -> low,high; h clocks per half.
  task automatic push_bit(input logic b, input int h);
    for (int k = 0; k < h; k++) exp_q.push_back(b);
    for (int k = 0; k < h; k++) exp_q.push_back(~b);
  endtask

  task automatic push_frame(input logic [31:0] w, input int h);
    logic [7:0] sp;
    logic       par;
    sp  = 8'hA5;
    par = 1'b0;
    for (int i = 7; i >= 0; i--) push_bit(sp[i], h);
    for (int i = 31; i >= 0; i--) begin
      push_bit(w[i], h);
      par = par ^ w[i];
    end
    push_bit(par, h);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Offers one word for one clock; returns on the first negedge after acceptance.
  task automatic send(input bit sel, input logic [31:0] w, input string tag);
    check({tag, "_rdy"}, sel ? din_ready3 : din_ready, 1'b1);
    if (sel) begin din3 = w; din_valid3 = 1'b1; end
    else     begin din  = w; din_valid  = 1'b1; end
    @(negedge clk);
    din_valid  = 1'b0;
    din_valid3 = 1'b0;
  endtask

  // Collects half-bits while tx_oe is high and compares them against exp_q.
  task automatic capture(input bit sel, input string tag, input int exp_len);
    int   n, bad, to;
    logic b;
    n = 0; bad = 0; to = 0;
    while (!cur_oe(sel) && to < 400) begin
      @(negedge clk);
      to++;
    end
    if (to >= 400) check({tag, "_start"}, cur_oe(sel), 1'b1);
    while (cur_oe(sel) && n < 1000) begin
      if (exp_q.size() == 0) bad++;
      else begin
        b = exp_q.pop_front();
        if (b !== cur_out(sel)) bad++;
      end
      n++;
      @(negedge clk);
    end
    check({tag, "_len"}, n, exp_len);
    check({tag, "_seq"}, bad, 0);
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_fd"}, cur_fd(sel), 1'b1);
  endtask

  initial begin
    int k, pulses, gap;

    // Reset state
    #1;
    check("rst_oe", tx_oe, 1'b0);
    check("rst_out", tx_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fd", frame_done, 1'b0);
    check("rst_cnt", frame_count, 16'd0);
    check("rst_rdy", din_ready, 1'b1);
    do_reset();

    // 32'h8000_0001 against a hand-built half-bit vector
    exp_q.delete();
    begin
      logic [81:0] v;
      v = {16'h9966, 64'h9555_5555_5555_5556, 2'b01};
      for (int i = 81; i >= 0; i--) exp_q.push_back(v[i]);
    end
    send(1'b0, 32'h8000_0001, "a");
    check("a_busy", busy, 1'b1);
    capture(1'b0, "a", 82);
    check("a_cnt", frame_count, 16'd1);
    k = 0; pulses = 0;
    while (!din_ready && k < 20) begin
      @(negedge clk);
      k++;
      if (frame_done) pulses++;
    end
    check("a_rdy_delay", k, 4);
    check("a_fd_once", pulses, 0);
    check("a_idle_oe", tx_oe, 1'b0);

    // 32'h0000_0007: odd number of ones, parity bit 1
    do_reset();
    exp_q.delete();
    push_frame(32'h0000_0007, 1);
    check("b_par_model", {31'd0, exp_q[80]}, 32'd1);
    send(1'b0, 32'h0000_0007, "b");
    capture(1'b0, "b", 82);
    check("b_cnt", frame_count, 16'd1);

    // Back-to-back with din_valid held high
    do_reset();
    exp_q.delete();
    push_frame(32'h1234_5678, 1);
    din = 32'h1234_5678;
    din_valid = 1'b1;
    @(negedge clk);
    din = 32'hDEAD_BEEF;
    capture(1'b0, "b2b1", 82);
    gap = 1;
    while (gap < 50) begin
      @(negedge clk);
      if (tx_oe) break;
      gap++;
    end
    din_valid = 1'b0;
    check("b2b_gap", gap, 5);
    push_frame(32'hDEAD_BEEF, 1);
    capture(1'b0, "b2b2", 82);
    check("b2b_cnt", frame_count, 16'd2);

    // Slow instance: three clocks per half-bit
    do_reset();
    exp_q.delete();
    push_frame(32'hA5C3_0F81, 3);
    send(1'b1, 32'hA5C3_0F81, "h3");
    capture(1'b1, "h3", 246);
    check("h3_cnt", frame_count3, 16'd1);

    // Reset in the middle of data bit 10
    do_reset();
    send(1'b0, 32'hFFFF_0000, "r");
    repeat (36) @(negedge clk);
    check("r_midframe_oe", tx_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("r_oe", tx_oe, 1'b0);
    check("r_out", tx_out, 1'b0);
    check("r_busy", busy, 1'b0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_done) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (frame_done) pulses++;
    end
    check("r_no_fd", pulses, 0);
    check("r_cnt", frame_count, 16'd0);
    check("r_rdy", din_ready, 1'b1);
    exp_q.delete();
    push_frame(32'h0F0F_3C3C, 1);
    send(1'b0, 32'h0F0F_3C3C, "r2");
    capture(1'b0, "r2", 82);
    check("r2_cnt", frame_count, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
